// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : shared op codes, sequencer state encoding, default latencies
// Revision   : 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  // Op codes shared with the multiply/divide unit
  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_DIV  = 2'd1;
  localparam logic [1:0] OP_MULT = 2'd2;

  localparam int MULT_LAT_DEF = 34;
  localparam int DIV_LAT_DEF  = 34;
  localparam int CNT_W_DEF    = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CAPT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_sequencer_hilo_regs.sv
// ============================================================================
// hilo_regs : architectural HI/LO with result capture and MTHI/MTLO writes
// Revision  : 1.0
// ============================================================================
`default_nettype none

module hilo_regs (
  input  logic        clk,
  input  logic        reset,
  input  logic        cap_en,
  input  logic [31:0] hi_cap,
  input  logic [31:0] lo_cap,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // Capture and MT writes are mutually exclusive by construction in the sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (cap_en) begin
      r_hi <= hi_cap;
      r_lo <= lo_cap;
    end else begin
      if (hi_we) r_hi <= wdata;
      if (lo_we) r_lo <= wdata;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// muldiv_sequencer : sequences multi-cycle MULT/DIV and owns architectural HI/LO
// Revision         : 1.0
// ============================================================================
`default_nettype none

module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op_sel,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [1:0]  controle,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        div0_in,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div0_exc,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [CNT_W-1:0] c_mult_last = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] c_div_last  = CNT_W'(DIV_LAT - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_ctrl, w_ctrl_nxt;
  logic [31:0]      r_op_a, w_op_a_nxt;
  logic [31:0]      r_op_b, w_op_b_nxt;
  logic             r_done, w_done_nxt;
  logic             r_div0, w_div0_nxt;
  logic             w_cap_en;
  logic             w_idle;
  logic             w_div0_hit;
  logic [CNT_W-1:0] w_last;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_div0_hit = (r_ctrl == OP_DIV) && div0_in;
  assign w_last     = (r_ctrl == OP_DIV) ? c_div_last : c_mult_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ctrl  <= OP_NONE;
      r_op_a  <= 32'd0;
      r_op_b  <= 32'd0;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ctrl  <= w_ctrl_nxt;
      r_op_a  <= w_op_a_nxt;
      r_op_b  <= w_op_b_nxt;
      r_done  <= w_done_nxt;
      r_div0  <= w_div0_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ctrl_nxt  = r_ctrl;
    w_op_a_nxt  = r_op_a;
    w_op_b_nxt  = r_op_b;
    w_done_nxt  = 1'b0;
    w_div0_nxt  = 1'b0;
    w_cap_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && (op_sel == OP_DIV || op_sel == OP_MULT)) begin
          w_op_a_nxt  = a_in;
          w_op_b_nxt  = b_in;
          w_ctrl_nxt  = op_sel;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_div0_hit) begin
          w_ctrl_nxt  = OP_NONE;
          w_div0_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == w_last) begin
          w_state_nxt = ST_CAPT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_CAPT: begin
        // A late divide-by-zero still wins over the capture
        w_ctrl_nxt  = OP_NONE;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
        if (w_div0_hit) begin
          w_div0_nxt = 1'b1;
        end else begin
          w_cap_en   = 1'b1;
          w_done_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ctrl_nxt  = OP_NONE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  hilo_regs u_hilo_regs (
    .clk    (clk),
    .reset  (reset),
    .cap_en (w_cap_en),
    .hi_cap (hi_in),
    .lo_cap (lo_in),
    .hi_we  (hi_we && w_idle),
    .lo_we  (lo_we && w_idle),
    .wdata  (wdata),
    .hi     (HI),
    .lo     (LO)
  );

  assign controle = r_ctrl;
  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign busy     = !w_idle;
  assign done     = r_done;
  assign div0_exc = r_div0;

endmodule

`default_nettype wire

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences multi-cycle MULT/DIV operations for the multiplier/divider unit, which consumes its `controle` code and operands.
- Holds operands stable, drives the control code for the required cycle count, then captures that unit's HI/LO outputs into architectural HI/LO registers.
- Sits between the main control FSM and the multiply/divide unit. Also serves MFHI/MFLO reads and MTHI/MTLO writes.

Parameters:
- MULT_LAT, 34, cycles `controle`=MULT is held before capture; covers 32 iterations plus output register.
- DIV_LAT, 34, same for DIV.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request a new operation (level, sampled per edge)
- op_sel  in  2  1=DIV, 2=MULT; 0 and 3 are invalid
- a_in  in  32  operand A from the register file
- b_in  in  32  operand B from the register file
- controle  out  2  registered control code to the multiply/divide unit (0=idle/clear, 1=DIV, 2=MULT)
- op_a  out  32  latched operand A to the multiply/divide unit
- op_b  out  32  latched operand B to the multiply/divide unit
- hi_in  in  32  HI output of the multiply/divide unit
- lo_in  in  32  LO output of the multiply/divide unit
- div0_in  in  1  divide-by-zero flag from the multiply/divide unit
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  32  MTHI/MTLO data
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; HI/LO valid from this cycle
- div0_exc  out  1  one-cycle pulse on divide by zero
- HI  out  32  architectural HI
- LO  out  32  architectural LO

Behaviour:
- Reset (async, immediate): state=IDLE, cnt=0; controle, op_a, op_b, HI, LO = 0; busy, done, div0_exc = 0.
- States: IDLE, RUN, CAPT.
- IDLE, on edge with start=1 and op_sel in {1,2}:
  - op_a<=a_in, op_b<=b_in, controle<=op_sel, cnt<=0, state->RUN.
  - start with op_sel 0 or 3 is ignored; no state change.
- RUN: cnt increments each edge. When cnt==LAT-1 (LAT selected by the latched op), go to CAPT. controle, op_a, op_b are held constant.
- CAPT, on the next edge: HI<=hi_in, LO<=lo_in, controle<=0, done<=1 for exactly one cycle, state->IDLE.
- Latency: controle is nonzero for LAT+1 cycles. done goes high LAT+1 edges after the start-sampling edge. With defaults, a new start is accepted on the edge after done asserts (throughput 36 cycles/op).
- Divide by zero: if div0_in=1 on any edge in RUN or CAPT with a DIV op:
  - state->IDLE, controle<=0, div0_exc pulses one cycle.
  - done stays 0; HI and LO are unchanged.
  - div0_in is ignored for MULT and in IDLE.
- start while busy: ignored, no queuing.
- MTHI/MTLO:
  - hi_we/lo_we are honoured only in IDLE: HI<=wdata / LO<=wdata. Both may be set together.
  - If start is accepted on the same edge, the write still happens; the later capture overwrites it.
  - Writes while busy are dropped.
- done and div0_exc are never high together.
- HI/LO change only at capture, on an MT write, or at reset.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no done, no exception.

Decomposition:
- Shared package (`muldiv_pkg`) holds:
  - op codes OP_NONE=2'd0, OP_DIV=2'd1, OP_MULT=2'd2;
  - state encoding IDLE/RUN/CAPT;
  - default latency constants.
- The multiply/divide unit uses the same op codes.
- One natural sub-module: `hilo_regs`, holding the architectural HI/LO with the capture port and MT write ports.

Test Plan:
- Reset, then MULT a=7, b=6 -> controle=2 for 35 cycles; done pulse 35 edges after start; HI=0, LO=42; busy is low the cycle after done.
- DIV a=100, b=7 -> done after 35 edges; LO=14 (quotient), HI=2 (remainder).
- Preload HI=0xAAAA, LO=0x5555 via MT writes, then DIV b=0 with div0_in asserted in RUN -> div0_exc one-cycle pulse, no done, HI/LO unchanged, controle=0 next cycle.
- Start MULT; assert start with op_sel=1 and different operands at cycle 10, plus hi_we=1 -> both ignored; op_a/op_b unchanged; HI result is from the original MULT.
- Assert reset at cycle 20 of a DIV -> all outputs 0 immediately; no done; a new MULT started after reset completes normally.
- start with op_sel=3 in IDLE -> stays IDLE, busy=0, controle=0; MT write of 0xDEADBEEF to LO on the same edge takes effect.
